// File: rtl/mux7_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux7_rr_scheduler
//
// Round-robin scheduler that shares one 7-to-1 selector among 7 requesters.
// The winner holds the selector for at most HOLD_CYCLES consecutive cycles
// while another requester is waiting. With no contender it keeps the selector
// for as long as it asks.
//
// Parameters:
//   HOLD_CYCLES - maximum tenure under contention, legal range 1..15
//
// Ports:
//   Clock     in   rising-edge system clock
//   Resetn    in   asynchronous active-low reset
//   Enable    in   0 releases any grant and blocks new grants
//   Req[6:0]  in   level-sensitive request vector, bit i = requester i
//   Grant     out  registered one-hot grant, all-zero when idle
//   MuxSelect out  registered index of the granted requester, 3'b111 when idle
//   Busy      out  registered, 1 while a grant is held
// ---------------------------------------------------------------------------
module mux7_rr_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic [6:0] Req,
    output logic [6:0] Grant,
    output logic [2:0] MuxSelect,
    output logic       Busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] SEL_IDLE   = 3'b111;

    state_t     state_q,      state_d;
    logic [2:0] last_q,       last_d;
    logic [3:0] cnt_q,        cnt_d;
    logic [6:0] grant_q,      grant_d;
    logic [2:0] mux_select_q, mux_select_d;
    logic       busy_q,       busy_d;

    // Circular first-one search starting just after 'last'.
    // Result bit 3 = a requester was found, bits 2:0 = its index.
    function automatic logic [3:0] rr_search(input logic [6:0] req,
                                             input logic [2:0] last);
        logic       found;
        logic [2:0] win;
        int         idx;
        found = 1'b0;
        win   = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            idx = (int'(last) + k) % 7;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
        return {found, win};
    endfunction

    logic [6:0] owner_mask;
    logic       owner_req;
    logic [6:0] others_req;
    logic [3:0] pick_all;
    logic [3:0] pick_others;
    logic       load;
    logic [2:0] load_idx;
    logic       release_grant;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        mux_select_d  = mux_select_q;
        busy_d        = busy_q;
        load          = 1'b0;
        load_idx      = 3'd0;
        release_grant = 1'b0;

        // The current owner is always Last while in ST_GRANT. Masking with a
        // shifted one avoids indexing Req with a 3-bit value that could be 7.
        owner_mask  = 7'b1 << last_q;
        owner_req   = |(Req & owner_mask);
        others_req  = Req & ~owner_mask;
        pick_all    = rr_search(Req, last_q);
        pick_others = rr_search(others_req, last_q);

        unique case (state_q)
            ST_IDLE: begin
                if (Enable && (|Req)) begin
                    load     = 1'b1;
                    load_idx = pick_all[2:0];
                end
            end
            ST_GRANT: begin
                if (!Enable) begin
                    release_grant = 1'b1;
                end else if (!owner_req) begin
                    // Owner finished: hand over without an idle cycle.
                    if (pick_others[3]) begin
                        load     = 1'b1;
                        load_idx = pick_others[2:0];
                    end else begin
                        release_grant = 1'b1;
                    end
                end else if (cnt_q == 4'd0) begin
                    // Tenure expired: rotate only if someone else is waiting,
                    // otherwise the owner keeps the grant and the count reloads.
                    if (pick_others[3]) begin
                        load     = 1'b1;
                        load_idx = pick_others[2:0];
                    end else begin
                        cnt_d = CNT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                release_grant = 1'b1;
            end
        endcase

        if (load) begin
            state_d      = ST_GRANT;
            last_d       = load_idx;
            cnt_d        = CNT_RELOAD;
            grant_d      = 7'b1 << load_idx;
            mux_select_d = load_idx;
            busy_d       = 1'b1;
        end

        // Last is deliberately kept on release so the next search resumes
        // after the previous owner.
        if (release_grant) begin
            state_d      = ST_IDLE;
            grant_d      = 7'd0;
            mux_select_d = SEL_IDLE;
            busy_d       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: only control state is reset here; there is no memory array
            // in this block, so every flop takes a defined reset value.
            state_q      <= ST_IDLE;
            last_q       <= 3'd6;
            cnt_q        <= 4'd0;
            grant_q      <= 7'd0;
            mux_select_q <= SEL_IDLE;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            mux_select_q <= mux_select_d;
            busy_q       <= busy_d;
        end
    end

    assign Grant     = grant_q;
    assign MuxSelect = mux_select_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux7_rr_scheduler
//
// Self-checking bench for mux7_rr_scheduler: a table of directed vectors,
// hand-written multi-cycle sequences for the corner cases, and a randomized
// run compared against a behavioural model that tracks the owner and how
// many cycles it has held the selector.
// ---------------------------------------------------------------------------
module tb_mux7_rr_scheduler;

    localparam int HOLD = 4;

    logic       Clock;
    logic       Resetn;
    logic       Enable;
    logic [6:0] Req;
    logic [6:0] Grant;
    logic [2:0] MuxSelect;
    logic       Busy;

    mux7_rr_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Enable    (Enable),
        .Req       (Req),
        .Grant     (Grant),
        .MuxSelect (MuxSelect),
        .Busy      (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model: owner index (-1 when idle), the last winner, and the
    // number of consecutive cycles the owner has held the selector.
    int m_owner;
    int m_last;
    int m_held;

    typedef struct {
        logic       en;
        logic [6:0] req;
        logic [6:0] grant;
        logic [2:0] sel;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_after(input logic [6:0] req, input int from);
        for (int k = 1; k <= 7; k++) begin
            if (req[(from + k) % 7]) return (from + k) % 7;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 6;
        m_held  = 0;
    endfunction

    function automatic void model_take(input int w);
        m_owner = w;
        m_last  = w;
        m_held  = 1;
    endfunction

    function automatic void model_step(input logic en, input logic [6:0] req);
        logic [6:0] others;
        int         w;
        if (m_owner < 0) begin
            if (en && req != 7'd0) model_take(first_after(req, m_last));
        end else if (!en) begin
            m_owner = -1;
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            w = first_after(others, m_last);
            if (!req[m_owner]) begin
                if (w >= 0) model_take(w);
                else m_owner = -1;
            end else if (m_held >= HOLD) begin
                if (w >= 0) model_take(w);
                else m_held = 1;
            end else begin
                m_held++;
            end
        end
    endfunction

    // Drive inputs, take one rising edge, advance the model with the same
    // inputs, then settle 1 time unit so outputs are sampled off the edge.
    task automatic cycle(input logic en, input logic [6:0] req);
        Enable = en;
        Req    = req;
        @(posedge Clock);
        model_step(en, req);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic [6:0] g,
                                 input logic [2:0] s);
        check({name, ".grant"}, 32'(Grant), 32'(g));
        check({name, ".sel"},   32'(MuxSelect), 32'(s));
        check({name, ".busy"},  32'(Busy), 32'(g != 7'd0));
    endtask

    task automatic check_model(input string name);
        logic [6:0] g;
        logic [2:0] s;
        g = 7'd0;
        s = 3'b111;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            s = 3'(m_owner);
        end
        check_outputs(name, g, s);
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        model_reset();
        #2;
        Resetn = 1'b1;
        #1;
    endtask

    initial begin
        Resetn = 1'b1;
        Enable = 1'b0;
        Req    = 7'd0;
        model_reset();
        #2;
        Resetn = 1'b0;
        #1;
        check_outputs("reset", 7'd0, 3'b111);
        #5;
        Resetn = 1'b1;

        // ---------------- Table-driven vectors (from reset, Last=6) --------
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 7'b1000001, 7'b0000001, 3'd0});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 7'b1000001, 7'b1000000, 3'd6});
        vecs.push_back('{1'b1, 7'b1000001, 7'b0000001, 3'd0});
        vecs.push_back('{1'b1, 7'b0000100, 7'b0000100, 3'd2});
        vecs.push_back('{1'b0, 7'b0000100, 7'b0000000, 3'd7});
        vecs.push_back('{1'b1, 7'b0000000, 7'b0000000, 3'd7});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 7'b0000011, 7'b0000001, 3'd0});
        vecs.push_back('{1'b1, 7'b0000011, 7'b0000010, 3'd1});

        do_reset();
        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].req);
            check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel);
        end

        // ---------------- Reset mid-grant, then first grant from index 0 ---
        do_reset();
        cycle(1'b1, 7'b0010000);
        check_outputs("pre_reset_grant4", 7'b0010000, 3'd4);
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset", 7'd0, 3'b111);
        #1;
        Resetn = 1'b1;
        cycle(1'b1, 7'b0001010);
        check_outputs("post_reset_first", 7'b0000010, 3'd1);

        // ---------------- Single requester held across tenure reloads ------
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 7'b0000100);
            check_outputs($sformatf("hold_single%0d", i), 7'b0000100, 3'd2);
        end

        // ---------------- Owner 3 drops with 5 pending --------------------
        cycle(1'b1, 7'b0001000);
        check_outputs("own3", 7'b0001000, 3'd3);
        cycle(1'b1, 7'b0101000);
        cycle(1'b1, 7'b0101000);
        check_outputs("own3_held", 7'b0001000, 3'd3);
        cycle(1'b1, 7'b0100000);
        check_outputs("drop3_to5", 7'b0100000, 3'd5);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 7'b0101000);
            check_outputs($sformatf("own5_reload%0d", i), 7'b0100000, 3'd5);
        end
        cycle(1'b1, 7'b0101000);
        check_outputs("rot5_to3", 7'b0001000, 3'd3);

        // ---------------- Owner 4, disable, re-enable all -----------------
        cycle(1'b1, 7'b0010000);
        check_outputs("own4", 7'b0010000, 3'd4);
        cycle(1'b0, 7'b0010000);
        check_outputs("disable", 7'd0, 3'b111);
        cycle(1'b1, 7'b1111111);
        check_outputs("reenable_all", 7'b0100000, 3'd5);

        // ---------------- Wrap from Last=6 --------------------------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 7'b0000011);
            check_outputs($sformatf("wrap0_%0d", i), 7'b0000001, 3'd0);
        end
        cycle(1'b1, 7'b0000011);
        check_outputs("wrap1", 7'b0000010, 3'd1);

        // ---------------- Randomized against the model --------------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic       en;
            logic [6:0] req;
            en  = ($urandom_range(0, 15) != 0);
            req = 7'($urandom) & 7'($urandom);
            if ($urandom_range(0, 7) == 0) req = 7'd0;
            cycle(en, req);
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux7_rr_scheduler.md
Name: mux7_rr_scheduler

Overview:
- Round-robin scheduler that shares one 7-to-1 selector datapath among 7 requesters.
- Produces a registered one-hot Grant and the matching 3-bit MuxSelect that drives the selector.
- Each requester holds the selector for a bounded tenure (HOLD_CYCLES) while others wait.
- Sits between the requesting sources and the 7-to-1 mux select input.

Parameters:
- HOLD_CYCLES, 4: maximum consecutive cycles a granted requester keeps the selector while another requester is pending. Legal range 1..15; the counter is 4 bits.

Ports:
- Clock  input  1  rising-edge system clock
- Resetn  input  1  asynchronous active-low reset
- Enable  input  1  scheduler enable; 0 forces release and blocks new grants
- Req  input  7  request vector; bit i = requester i wants the selector
- Grant  output  7  registered one-hot grant; all-zero when idle
- MuxSelect  output  3  registered select index 0..6 of the granted requester; 3'b111 when idle (the mux outputs 0 for this code)
- Busy  output  1  registered; 1 while in GRANT state

Behaviour:
- Interface: one clock (Clock). Reset (Resetn) is asynchronous and active-low.
- Reset values (applied immediately when Resetn falls, no clock needed):
  - state = IDLE, Grant = 7'b0, MuxSelect = 3'b111, Busy = 0
  - round-robin pointer Last = 6, so the first search starts at index 0
  - tenure counter Cnt = 0
- Search function: the first i with Req[i]=1, scanning circularly from (Last+1) mod 7. Wrap: Last=6 scans 0,1,..,6; Last=3 scans 4,5,6,0,1,2,3.
- All outputs are registered and change only on a rising Clock edge (except reset).
- State IDLE, at each edge:
  - Enable=0 or Req=0: remain IDLE; outputs stay at idle values.
  - Otherwise: winner w = search; Grant = 1<<w, MuxSelect = w, Last = w, Cnt = HOLD_CYCLES-1, Busy = 1; go to GRANT.
  - Latency: a request present before edge N is visible on Grant after edge N (one edge).
- State GRANT (current owner c = Last), at each edge, evaluated in priority order:
  1. Enable=0: release. Grant = 0, MuxSelect = 3'b111, Busy = 0, go to IDLE. Last is preserved.
  2. Req[c]=0 (owner done): winner w = search over Req with Req[c] treated as 0.
     - If w exists: grant w directly (no idle cycle); Cnt = HOLD_CYCLES-1.
     - Else: release to IDLE as in rule 1.
  3. Req[c]=1 and Cnt=0 (tenure expired): winner w = search over Req with Req[c] masked.
     - If w exists: grant w; Cnt = HOLD_CYCLES-1.
     - Else: c keeps the grant with no output glitch; Cnt reloads to HOLD_CYCLES-1.
  4. Otherwise: Cnt = Cnt-1; outputs unchanged.
- Tenure: with contention, an owner holds Grant for exactly HOLD_CYCLES consecutive cycles. HOLD_CYCLES=1 rotates every cycle.
- Invariants:
  - Grant is one-hot or zero.
  - MuxSelect equals the index of the set Grant bit; it is 3'b111 exactly when Grant=0.
  - Busy equals |Grant.
- Requests are level-sensitive and not latched; a request withdrawn before it is granted is lost.
- No combinational path from Req or Enable to any output.
- Reset mid-grant: outputs clear asynchronously. After Resetn rises, the next grant searches from index 0.

Test Plan:
1. Assert Resetn=0 mid-cycle with Grant=7'b0010000 -> Grant=0, MuxSelect=3'b111 and Busy=0 before the next edge. Release reset with Req=7'b0001010 -> first grant is index 1 (MuxSelect=1).
2. Enable=1, Req=7'b0000100 held, HOLD=4 -> Grant=7'b0000100 and MuxSelect=2 after 1 edge, then held continuously for 20 cycles with no gap at tenure reloads.
3. Req=7'b1000001 held, HOLD=4 -> grant index 0 for 4 cycles, then 6 for 4, then 0 for 4, repeating. Busy stays 1 with no idle cycles.
4. Owner 3 granted with Req[5]=1 pending; drop Req[3] after 2 cycles -> next edge Grant=7'b0100000, MuxSelect=5. No idle cycle; Cnt reloads.
5. Wrap case: Last=6 state reached, then Req=7'b0000011 -> index 0 granted first; index 1 after 4 cycles.
6. Owner 4 granted, drop Enable -> next edge Grant=0, MuxSelect=3'b111, Busy=0. Re-enable with Req=7'b1111111 -> index 5 granted.
